// File: rtl/rdw_stage.sv
// rdw_stage: read-data-wait stage between MEM and WB; waits for data_ok, extends load data, drops orphaned responses
module rdw_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  input  logic        wb_flush,
  input  logic        mem_kill_pend,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] csr_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  input  logic [7:0]  mem_op,
  input  logic        res_from_mem,
  input  logic        res_from_mul,
  input  logic        res_from_div,
  input  logic        res_from_csr,
  input  logic        mem_we,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic [31:0] data_in,
  input  logic        data_valid_in,
  input  logic        has_exception,
  input  logic [46:0] exc_info,
  input  logic        ertn,
  input  logic        rdcntid,
  input  logic        tlb,
  input  logic        cacop,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        data_wait,
  output logic        this_flush,
  output logic        this_tlb_refetch,
  output logic        this_cacop_refetch,
  output logic [31:0] result_bypass,
  output logic [31:0] pc_out,
  output logic [31:0] result_out,
  output logic        gr_we_out,
  output logic [4:0]  dest_out,
  output logic        has_exception_out,
  output logic [46:0] exc_info_out,
  output logic        ertn_out,
  output logic        rdcntid_out,
  output logic        tlb_out,
  output logic        cacop_out
);
  localparam int SW = DISCARD_W + 2;
  localparam logic [DISCARD_W-1:0] DISC_MAX = '1;
  localparam int WB_W = 32 + 32 + 1 + 5 + 1 + 47 + 4;
  logic                 got_q, got_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [DISCARD_W-1:0] disc_cnt_q, disc_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WB_W-1:0]      wb_q, wb_d;
  logic                 needs, claim, ready_go, fire, disc_zero;
  logic [31:0]          ld_src, lane, mem_res;
  logic [SW-1:0]        disc_sum;
  logic                 unused_ok;
  assign unused_ok = &{1'b0, mem_op[7:5], mem_op[2]};
  assign disc_zero = disc_cnt_q == '0;
  assign needs = in_valid & (res_from_mem | mem_we) & ~has_exception;
  assign data_wait = needs & ~data_valid_in & ~got_q & disc_zero;
  assign claim = data_ok & data_wait;
  assign this_flush = in_valid & (has_exception | ertn | wb_flush);
  assign this_tlb_refetch = in_valid & tlb;
  assign this_cacop_refetch = in_valid & cacop;
  assign ready_go = ~in_valid | this_flush | ~needs | data_valid_in | got_q | claim;
  assign fire = in_valid & ready_go & out_ready;
  assign in_ready = ~rst & (~in_valid | ready_go & out_ready);
  assign ld_src = data_valid_in ? data_in : got_q ? rdata_q : rdata;
  assign lane = ld_src >> {alu_result[1:0], 3'b000};
  assign mem_res = mem_op[0] ? {{24{lane[7]}}, lane[7:0]}
                 : mem_op[1] ? {{16{lane[15]}}, lane[15:0]}
                 : mem_op[3] ? {24'b0, lane[7:0]}
                 : mem_op[4] ? {16'b0, lane[15:0]}
                 : ld_src;
  assign result_bypass = res_from_mem ? mem_res
                       : res_from_mul ? mul_result
                       : res_from_div ? div_result
                       : res_from_csr ? csr_result
                       : alu_result;
  // a data_ok consumed by the discard counter is never claimed, so the decrement needs no extra gating
  assign disc_sum = SW'(disc_cnt_q) + SW'(mem_kill_pend) + SW'(flush & data_wait)
                  - SW'(data_ok & ~disc_zero);
  always_comb begin
    got_d = flush | fire ? 1'b0 : claim & ~out_ready ? 1'b1 : got_q;
    rdata_d = ~fire & claim & ~out_ready ? rdata : rdata_q;
    disc_cnt_d = disc_sum > SW'(DISC_MAX) ? DISC_MAX : disc_sum[DISCARD_W-1:0];
    out_valid_d = out_ready ? in_valid & ready_go & ~flush : out_valid_q;
    wb_d = fire ? {pc, result_bypass, gr_we, dest, has_exception, exc_info, ertn, rdcntid, tlb, cacop} : wb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      got_q       <= 1'b0;
      rdata_q     <= '0;
      disc_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= {32'h1c00_0000, {(WB_W-32){1'b0}}};
    end else begin
      got_q       <= got_d;
      rdata_q     <= rdata_d;
      disc_cnt_q  <= disc_cnt_d;
      out_valid_q <= out_valid_d;
      wb_q        <= wb_d;
    end
  end
  assign out_valid = out_valid_q;
  assign {pc_out, result_out, gr_we_out, dest_out, has_exception_out, exc_info_out,
          ertn_out, rdcntid_out, tlb_out, cacop_out} = wb_q;
endmodule

// File: tb/tb_rdw_stage.sv
// tb_rdw_stage: directed scenarios plus randomized traffic against a behavioural model of rdw_stage
module tb_rdw_stage;
  logic        clk = 0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush, wb_flush, mem_kill_pend;
  logic [31:0] pc, alu_result, csr_result, mul_result, div_result;
  logic [7:0]  mem_op;
  logic        res_from_mem, res_from_mul, res_from_div, res_from_csr, mem_we, gr_we;
  logic [4:0]  dest;
  logic [31:0] data_in;
  logic        data_valid_in, has_exception;
  logic [46:0] exc_info;
  logic        ertn, rdcntid, tlb, cacop, data_ok;
  logic [31:0] rdata;
  logic        data_wait, this_flush, this_tlb_refetch, this_cacop_refetch;
  logic [31:0] result_bypass, pc_out, result_out;
  logic        gr_we_out, has_exception_out, ertn_out, rdcntid_out, tlb_out, cacop_out;
  logic [4:0]  dest_out;
  logic [46:0] exc_info_out;
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  rdw_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .wb_flush(wb_flush), .mem_kill_pend(mem_kill_pend),
    .pc(pc), .alu_result(alu_result), .csr_result(csr_result), .mul_result(mul_result),
    .div_result(div_result), .mem_op(mem_op), .res_from_mem(res_from_mem),
    .res_from_mul(res_from_mul), .res_from_div(res_from_div), .res_from_csr(res_from_csr),
    .mem_we(mem_we), .gr_we(gr_we), .dest(dest), .data_in(data_in),
    .data_valid_in(data_valid_in), .has_exception(has_exception), .exc_info(exc_info),
    .ertn(ertn), .rdcntid(rdcntid), .tlb(tlb), .cacop(cacop), .data_ok(data_ok), .rdata(rdata),
    .data_wait(data_wait), .this_flush(this_flush), .this_tlb_refetch(this_tlb_refetch),
    .this_cacop_refetch(this_cacop_refetch), .result_bypass(result_bypass), .pc_out(pc_out),
    .result_out(result_out), .gr_we_out(gr_we_out), .dest_out(dest_out),
    .has_exception_out(has_exception_out), .exc_info_out(exc_info_out), .ertn_out(ertn_out),
    .rdcntid_out(rdcntid_out), .tlb_out(tlb_out), .cacop_out(cacop_out)
  );

  task automatic idle();
    in_valid = 0; out_ready = 1; flush = 0; wb_flush = 0; mem_kill_pend = 0;
    pc = 32'h1c00_0100; alu_result = 0; csr_result = 0; mul_result = 0; div_result = 0;
    mem_op = 0; res_from_mem = 0; res_from_mul = 0; res_from_div = 0; res_from_csr = 0;
    mem_we = 0; gr_we = 0; dest = 0; data_in = 0; data_valid_in = 0; has_exception = 0;
    exc_info = 0; ertn = 0; rdcntid = 0; tlb = 0; cacop = 0; data_ok = 0; rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] op, input logic [1:0] off);
    in_valid = 1; res_from_mem = 1; gr_we = 1; dest = 5'd7; mem_op = op;
    alu_result = {30'h0000_1000, off};
  endtask

  function automatic logic [31:0] load_val(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    if (op[0]) return 32'($signed(s[7:0]));
    if (op[1]) return 32'($signed(s[15:0]));
    if (op[3]) return s & 32'hFF;
    if (op[4]) return s & 32'hFFFF;
    return w;
  endfunction

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total++; if (pc_out !== 32'h1c00_0000) $display("FAIL reset_pc_out: got %h want 1c000000", pc_out); else pass_cnt++;
    total++; if (result_out !== 32'h0) $display("FAIL reset_result_out: got %h want 0", result_out); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total++; if (exc_info_out !== 47'h0) $display("FAIL reset_exc_info: got %h want 0", exc_info_out); else pass_cnt++;
    rst = 0; mem_kill_pend = 1;
    step();
    mem_kill_pend = 0; rst = 1;
    step();
    rst = 0;
    total++; if (dut.disc_cnt_q !== 2'd0) $display("FAIL reset_mid_disc: got %0d want 0", dut.disc_cnt_q); else pass_cnt++;
  endtask

  task automatic test_lb_same_cycle();
    idle(); load(8'h01, 2'd2); data_ok = 1; rdata = 32'h0080_0000;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL lb_in_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL lb_out_valid: got %b want 1", out_valid); else pass_cnt++;
    total++; if (result_out !== 32'hFFFF_FF80) $display("FAIL lb_result: got %h want ffffff80", result_out); else pass_cnt++;
    idle();
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL lb_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_lhu_stall();
    idle(); load(8'h10, 2'd2); out_ready = 0; data_ok = 1; rdata = 32'h8001_0000;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL lhu_in_ready0: got %b want 0", in_ready); else pass_cnt++;
    step();
    data_ok = 0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL lhu_hold_ready: got %b want 0", in_ready); else pass_cnt++;
      total++; if (result_bypass !== 32'h0000_8001) $display("FAIL lhu_hold_data: got %h want 00008001", result_bypass); else pass_cnt++;
      step();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL lhu_release_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL lhu_out_valid: got %b want 1", out_valid); else pass_cnt++;
    total++; if (result_out !== 32'h0000_8001) $display("FAIL lhu_result: got %h want 00008001", result_out); else pass_cnt++;
    idle(); step();
  endtask

  task automatic test_flush_discard();
    idle(); load(8'h04, 2'd0);
    #1;
    total++; if (data_wait !== 1'b1) $display("FAIL flush_wait: got %b want 1", data_wait); else pass_cnt++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_waiting_ov: got %b want 0", out_valid); else pass_cnt++;
    flush = 1;
    step();
    idle();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_ov: got %b want 0", out_valid); else pass_cnt++;
    total++; if (dut.disc_cnt_q !== 2'd1) $display("FAIL flush_disc: got %0d want 1", dut.disc_cnt_q); else pass_cnt++;
    data_ok = 1; rdata = 32'hDEAD_0000;
    step();
    data_ok = 0;
    total++; if (dut.disc_cnt_q !== 2'd0) $display("FAIL flush_drop: got %0d want 0", dut.disc_cnt_q); else pass_cnt++;
    load(8'h04, 2'd0);
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_lw_wait: got %b want 0", out_valid); else pass_cnt++;
    data_ok = 1; rdata = 32'h1234_5678;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL flush_lw_ov: got %b want 1", out_valid); else pass_cnt++;
    total++; if (result_out !== 32'h1234_5678) $display("FAIL flush_lw_result: got %h want 12345678", result_out); else pass_cnt++;
    idle(); step();
  endtask

  task automatic test_discard_counter();
    idle(); mem_kill_pend = 1;
    step();
    total++; if (dut.disc_cnt_q !== 2'd1) $display("FAIL disc_inc: got %0d want 1", dut.disc_cnt_q); else pass_cnt++;
    data_ok = 1;
    step();
    total++; if (dut.disc_cnt_q !== 2'd1) $display("FAIL disc_inc_dec: got %0d want 1", dut.disc_cnt_q); else pass_cnt++;
    data_ok = 0;
    for (int i = 0; i < 4; i++) step();
    mem_kill_pend = 0;
    total++; if (dut.disc_cnt_q !== 2'd3) $display("FAIL disc_sat: got %0d want 3", dut.disc_cnt_q); else pass_cnt++;
    load(8'h04, 2'd0);
    #1;
    total++; if (data_wait !== 1'b0) $display("FAIL disc_blocks_wait: got %b want 0", data_wait); else pass_cnt++;
    in_valid = 0; data_ok = 1;
    for (int i = 0; i < 4; i++) step();
    total++; if (dut.disc_cnt_q !== 2'd0) $display("FAIL disc_floor: got %0d want 0", dut.disc_cnt_q); else pass_cnt++;
    idle(); step();
  endtask

  task automatic test_exception();
    idle(); load(8'h04, 2'd0); has_exception = 1; exc_info = 47'h5A5A_1234_5678;
    #1;
    total++; if (this_flush !== 1'b1) $display("FAIL exc_this_flush: got %b want 1", this_flush); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL exc_in_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL exc_ov: got %b want 1", out_valid); else pass_cnt++;
    total++; if (has_exception_out !== 1'b1) $display("FAIL exc_flag: got %b want 1", has_exception_out); else pass_cnt++;
    total++; if (exc_info_out !== 47'h5A5A_1234_5678) $display("FAIL exc_info: got %h want 5a5a12345678", exc_info_out); else pass_cnt++;
    idle(); step();
  endtask

  task automatic test_early_data();
    idle(); load(8'h04, 2'd0); out_ready = 0; data_valid_in = 1; data_in = 32'hDEAD_BEEF;
    data_ok = 1; rdata = 32'h0BAD_0BAD;
    #1;
    total++; if (data_wait !== 1'b0) $display("FAIL early_wait: got %b want 0", data_wait); else pass_cnt++;
    total++; if (result_bypass !== 32'hDEAD_BEEF) $display("FAIL early_bypass: got %h want deadbeef", result_bypass); else pass_cnt++;
    step();
    data_ok = 0; data_valid_in = 0;
    #1;
    total++; if (data_wait !== 1'b1) $display("FAIL early_not_claimed: got %b want 1", data_wait); else pass_cnt++;
    data_valid_in = 1; out_ready = 1;
    step();
    total++; if (result_out !== 32'hDEAD_BEEF) $display("FAIL early_result: got %h want deadbeef", result_out); else pass_cnt++;
    idle(); step();
  endtask

  task automatic test_random();
    int disc;
    bit got, ov;
    logic [31:0] rq, pc_e, res_e;
    logic [4:0] dest_e;
    idle(); rst = 1; step(); rst = 0;
    disc = 0; got = 0; ov = 0; rq = 0; pc_e = 32'h1c00_0000; res_e = 0; dest_e = 0;
    for (int n = 0; n < 2000; n++) begin
      int k;
      bit needs, wt, take, done, fire, tf;
      logic [31:0] word, exp;
      k = $urandom_range(0, 9);
      in_valid = $urandom_range(0, 3) != 0;
      mem_op = k < 8 ? 8'(1 << k) : 8'h0;
      res_from_mem = k < 5; mem_we = k >= 5 && k <= 7;
      res_from_mul = $urandom_range(0, 3) == 0; res_from_div = $urandom_range(0, 3) == 0;
      res_from_csr = $urandom_range(0, 3) == 0;
      pc = $urandom; alu_result = $urandom; csr_result = $urandom; mul_result = $urandom;
      div_result = $urandom; data_in = $urandom; rdata = $urandom; dest = 5'($urandom);
      gr_we = ~mem_we; exc_info = 47'({$urandom, $urandom});
      has_exception = $urandom_range(0, 15) == 0; ertn = $urandom_range(0, 15) == 0;
      wb_flush = $urandom_range(0, 15) == 0; flush = $urandom_range(0, 15) == 0;
      mem_kill_pend = $urandom_range(0, 15) == 0; data_ok = $urandom_range(0, 1);
      data_valid_in = $urandom_range(0, 7) == 0; out_ready = $urandom_range(0, 3) != 0;
      tlb = $urandom_range(0, 1); cacop = $urandom_range(0, 1); rdcntid = $urandom_range(0, 1);
      #1;
      needs = in_valid && (res_from_mem || mem_we) && !has_exception;
      wt = needs && !data_valid_in && !got && disc == 0;
      take = wt && data_ok;
      tf = in_valid && (has_exception || ertn || wb_flush);
      done = !in_valid || tf || !needs || data_valid_in || got || take;
      word = data_valid_in ? data_in : got ? rq : rdata;
      exp = res_from_mem ? load_val(mem_op, alu_result[1:0], word) : res_from_mul ? mul_result
          : res_from_div ? div_result : res_from_csr ? csr_result : alu_result;
      total++; if (data_wait !== wt) $display("FAIL rnd_data_wait @%0d: got %b want %b", n, data_wait, wt); else pass_cnt++;
      total++; if (in_ready !== (!in_valid || (done && out_ready))) $display("FAIL rnd_in_ready @%0d: got %b want %b", n, in_ready, !in_valid || (done && out_ready)); else pass_cnt++;
      total++; if (result_bypass !== exp) $display("FAIL rnd_bypass @%0d: got %h want %h", n, result_bypass, exp); else pass_cnt++;
      total++; if ({this_flush, this_tlb_refetch, this_cacop_refetch} !== {tf, in_valid && tlb, in_valid && cacop}) $display("FAIL rnd_flags @%0d: got %b want %b", n, {this_flush, this_tlb_refetch, this_cacop_refetch}, {tf, in_valid && tlb, in_valid && cacop}); else pass_cnt++;
      @(posedge clk);
      fire = in_valid && done && out_ready;
      if (out_ready) ov = in_valid && done && !flush;
      if (fire) begin pc_e = pc; res_e = exp; dest_e = dest; end
      if (flush || fire) got = 0;
      else if (take && !out_ready) begin got = 1; rq = rdata; end
      disc = disc + int'(mem_kill_pend) + int'(flush && wt) - ((data_ok && disc > 0) ? 1 : 0);
      if (disc > 3) disc = 3;
      #1;
      total++; if (out_valid !== ov) $display("FAIL rnd_out_valid @%0d: got %b want %b", n, out_valid, ov); else pass_cnt++;
      total++; if (result_out !== res_e) $display("FAIL rnd_result @%0d: got %h want %h", n, result_out, res_e); else pass_cnt++;
      total++; if (pc_out !== pc_e) $display("FAIL rnd_pc @%0d: got %h want %h", n, pc_out, pc_e); else pass_cnt++;
      total++; if (dest_out !== dest_e) $display("FAIL rnd_dest @%0d: got %h want %h", n, dest_out, dest_e); else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lb_same_cycle();
    test_lhu_stall();
    test_flush_discard();
    test_discard_counter();
    test_exception();
    test_early_data();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
